// File: rtl/grf_pkg.sv
// Shared sizing, Tuse/Tnew encodings and entry types for the GRF issue scoreboard.
package grf_pkg;
  localparam int NREG     = 32;
  localparam int AW       = 5;
  localparam int TW       = 3;
  localparam int MAX_PEND = 3;
  localparam int PW       = $clog2(MAX_PEND + 1);

  typedef logic [TW-1:0] tcnt_t;
  typedef logic [PW-1:0] pend_t;

  // Tuse: cycles from decode until the consumer needs the operand
  localparam tcnt_t TUSE_D = 3'd0;
  localparam tcnt_t TUSE_E = 3'd1;
  localparam tcnt_t TUSE_M = 3'd2;

  // Tnew at issue for the common producer classes
  localparam tcnt_t TNEW_LINK = 3'd0;
  localparam tcnt_t TNEW_ALU  = 3'd1;
  localparam tcnt_t TNEW_LOAD = 3'd2;
endpackage

// File: rtl/grf_scoreboard_sb_entry.sv
// One GRF register's tracking state: pending-write count and a saturating Tnew down-counter.
module sb_entry
  import grf_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  flush,
  input  logic  inc,
  input  logic  dec,
  input  tcnt_t lat,
  output pend_t pend,
  output tcnt_t tnew,
  output logic  ovf,
  output logic  unf
);
  localparam pend_t PEND_MAX = pend_t'(MAX_PEND);

  // A matched issue/retire pair nets to zero, so neither flag fires then.
  assign ovf = inc & ~dec & (pend == PEND_MAX);
  assign unf = dec & ~inc & (pend == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= '0;
      tnew <= '0;
    end else if (flush) begin
      pend <= '0;
      tnew <= '0;
    end else begin
      if (inc && !dec && pend != PEND_MAX)
        pend <= pend + 1'b1;
      else if (dec && !inc && pend != '0)
        pend <= pend - 1'b1;

      if (inc)
        tnew <= lat;
      else if (tnew != '0)
        tnew <= tnew - 1'b1;
    end
  end
endmodule

// File: rtl/grf_scoreboard.sv
// Issue-stage GRF scoreboard: tracks in-flight producers per register and raises stall on Tnew > Tuse.
module grf_scoreboard
  import grf_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [AW-1:0]   rs_addr,
  input  logic [AW-1:0]   rt_addr,
  input  logic            rs_use,
  input  logic            rt_use,
  input  logic [TW-1:0]   tuse_rs,
  input  logic [TW-1:0]   tuse_rt,
  input  logic            issue_valid,
  input  logic            issue_wr,
  input  logic [AW-1:0]   issue_dst,
  input  logic [TW-1:0]   issue_lat,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  output logic            stall,
  output logic [NREG-1:0] busy_vec,
  output logic            err
);
  tcnt_t           tnew [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] ovf;
  logic [NREG-1:0] unf;
  logic            acc;
  logic            ret;
  logic            hz_rs;
  logic            hz_rt;

  // stall only looks at registered state and source fields, never issue_* or wb_*
  assign hz_rs = rs_use & busy[rs_addr] & (tnew[rs_addr] > tuse_rs);
  assign hz_rt = rt_use & busy[rt_addr] & (tnew[rt_addr] > tuse_rt);
  assign stall = hz_rs | hz_rt;

  assign acc = issue_valid & ~stall & issue_wr & (issue_dst != '0) & ~flush;
  assign ret = wb_valid & (wb_addr != '0) & ~flush;

  assign tnew[0] = '0;
  assign busy[0] = 1'b0;
  assign ovf[0]  = 1'b0;
  assign unf[0]  = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_ent
    pend_t pend;

    sb_entry u_ent (
      .clk  (clk),
      .rst  (rst),
      .flush(flush),
      .inc  (acc && (issue_dst == AW'(r))),
      .dec  (ret && (wb_addr == AW'(r))),
      .lat  (issue_lat),
      .pend (pend),
      .tnew (tnew[r]),
      .ovf  (ovf[r]),
      .unf  (unf[r])
    );

    assign busy[r] = (pend != '0);
  end

  assign busy_vec = busy;

  // err is sticky across flush; only reset clears it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      err <= 1'b0;
    else if ((|ovf) || (|unf))
      err <= 1'b1;
  end
endmodule

// File: tb/tb_grf_scoreboard.sv
// Self-checking bench: expected stall/busy_vec/err are queued per cycle and compared mid-cycle.
module tb_grf_scoreboard;
  import grf_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [AW-1:0]   rs_addr, rt_addr;
  logic            rs_use, rt_use;
  logic [TW-1:0]   tuse_rs, tuse_rt;
  logic            issue_valid, issue_wr;
  logic [AW-1:0]   issue_dst;
  logic [TW-1:0]   issue_lat;
  logic            wb_valid;
  logic [AW-1:0]   wb_addr;
  logic            stall;
  logic [NREG-1:0] busy_vec;
  logic            err;

  grf_scoreboard dut (
    .clk(clk), .rst(rst), .flush(flush),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_use(rs_use), .rt_use(rt_use),
    .tuse_rs(tuse_rs), .tuse_rt(tuse_rt),
    .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_dst(issue_dst), .issue_lat(issue_lat),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .stall(stall), .busy_vec(busy_vec), .err(err)
  );

  always #5 clk = ~clk;

  typedef enum int {K_STALL, K_BUSY, K_ERR} kind_t;
  typedef struct {
    string           tag;
    kind_t           kind;
    logic [NREG-1:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [NREG-1:0] obs, input logic [NREG-1:0] want);
    n_chk++;
    if (obs === want) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, want);
  endtask

  task automatic push(input string tag, input kind_t k, input logic [NREG-1:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = k;
    e.v    = v;
    exp_q.push_back(e);
  endtask

  task automatic exp3(input string tag, input logic s, input logic [NREG-1:0] b, input logic e);
    push({tag, ".stall"}, K_STALL, {{(NREG-1){1'b0}}, s});
    push({tag, ".busy"},  K_BUSY,  b);
    push({tag, ".err"},   K_ERR,   {{(NREG-1){1'b0}}, e});
  endtask

  task automatic drain();
    exp_t            e;
    logic [NREG-1:0] obs;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      case (e.kind)
        K_STALL: obs = {{(NREG-1){1'b0}}, stall};
        K_BUSY:  obs = busy_vec;
        default: obs = {{(NREG-1){1'b0}}, err};
      endcase
      chk(e.tag, obs, e.v);
    end
  endtask

  function automatic logic [NREG-1:0] bit_of(input int r);
    logic [NREG-1:0] v;
    v = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  task automatic idle();
    flush = 0; rs_addr = '0; rt_addr = '0; rs_use = 0; rt_use = 0;
    tuse_rs = '0; tuse_rt = '0; issue_valid = 0; issue_wr = 0;
    issue_dst = '0; issue_lat = '0; wb_valid = 0; wb_addr = '0;
  endtask

  task automatic cyc_begin();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic cyc_end();
    #3;
    drain();
  endtask

  task automatic iss(input int dst, input int lat);
    issue_valid = 1; issue_wr = 1;
    issue_dst = AW'(dst); issue_lat = TW'(lat);
  endtask

  task automatic rd_rs(input int a, input int u);
    rs_use = 1; rs_addr = AW'(a); tuse_rs = TW'(u);
  endtask

  task automatic rd_rt(input int a, input int u);
    rt_use = 1; rt_addr = AW'(a); tuse_rt = TW'(u);
  endtask

  task automatic wb(input int a);
    wb_valid = 1; wb_addr = AW'(a);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0;
    idle();
    #2;
    exp3("reset", 0, '0, 0);
    drain();
    #6 rst = 1;

    // load-use, Tuse 0: two stall cycles
    cyc_begin(); iss(8, 2); exp3("lu0_iss", 0, '0, 0); cyc_end();
    for (int k = 0; k < 3; k++) begin
      cyc_begin(); rd_rs(8, 0); exp3($sformatf("lu0_c%0d", k), k < 2, bit_of(8), 0); cyc_end();
    end
    cyc_begin(); wb(8); exp3("lu0_wb", 0, bit_of(8), 0); cyc_end();

    // load-use on rt, Tuse 1: one stall cycle
    cyc_begin(); iss(8, 2); exp3("lu1_iss", 0, '0, 0); cyc_end();
    for (int k = 0; k < 2; k++) begin
      cyc_begin(); rd_rt(8, 1); exp3($sformatf("lu1_c%0d", k), k == 0, bit_of(8), 0); cyc_end();
    end
    cyc_begin(); wb(8); exp3("lu1_wb", 0, bit_of(8), 0); cyc_end();

    // $0 is never tracked
    cyc_begin(); iss(0, 3); exp3("r0_iss", 0, '0, 0); cyc_end();
    cyc_begin(); rd_rs(0, 0); exp3("r0_rd", 0, '0, 0); cyc_end();

    // same-cycle issue never stalls its own reader
    cyc_begin(); iss(6, 3); rd_rs(6, 0); exp3("same_cyc", 0, '0, 0); cyc_end();
    cyc_begin(); rd_rs(6, 2); wb(6); exp3("r6_tuse2", 1, bit_of(6), 0); cyc_end();

    // double producer: youngest Tnew wins, two retires needed
    cyc_begin(); iss(5, 3); exp3("dp_iss1", 0, '0, 0); cyc_end();
    cyc_begin(); iss(5, 1); exp3("dp_iss2", 0, bit_of(5), 0); cyc_end();
    cyc_begin(); rd_rs(5, 0); exp3("dp_t1", 1, bit_of(5), 0); cyc_end();
    cyc_begin(); rd_rs(5, 0); wb(5); exp3("dp_t0", 0, bit_of(5), 0); cyc_end();
    cyc_begin(); wb(5); exp3("dp_ret1", 0, bit_of(5), 0); cyc_end();
    cyc_begin(); exp3("dp_ret2", 0, '0, 0); cyc_end();

    // simultaneous issue+retire on $9, then underflow on $10, then flush
    cyc_begin(); iss(9, 1); exp3("sim_iss", 0, '0, 0); cyc_end();
    cyc_begin(); iss(9, 3); wb(9); exp3("sim_both", 0, bit_of(9), 0); cyc_end();
    for (int k = 0; k < 4; k++) begin
      cyc_begin(); rd_rs(9, 0); exp3($sformatf("sim_c%0d", k), k < 3, bit_of(9), 0); cyc_end();
    end
    cyc_begin(); wb(10); exp3("unf_wb", 0, bit_of(9), 0); cyc_end();
    cyc_begin(); flush = 1; iss(11, 2); wb(9); exp3("unf_err", 0, bit_of(9), 1); cyc_end();
    cyc_begin(); exp3("flush1", 0, '0, 1); cyc_end();

    // asynchronous reset mid-traffic
    cyc_begin(); iss(7, 4); exp3("ar_iss", 0, '0, 1); cyc_end();
    cyc_begin(); rd_rs(7, 0); exp3("ar_pre", 1, bit_of(7), 1); cyc_end();
    #2 rst = 0;
    #1 exp3("ar_async", 0, '0, 0); drain();
    #1 rst = 1;

    // overflow: four issues to $3 saturate pend at 3
    for (int k = 0; k < 4; k++) begin
      cyc_begin(); iss(3, 0); exp3($sformatf("ovf_i%0d", k), 0, (k == 0) ? '0 : bit_of(3), 0); cyc_end();
    end
    cyc_begin(); wb(3); exp3("ovf_err", 0, bit_of(3), 1); cyc_end();
    cyc_begin(); wb(3); exp3("ovf_r1", 0, bit_of(3), 1); cyc_end();
    cyc_begin(); flush = 1; iss(4, 1); exp3("ovf_r2", 0, bit_of(3), 1); cyc_end();
    cyc_begin(); exp3("flush2", 0, '0, 1); cyc_end();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
